// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the IC/DM memory-port arbiter: bus width, FSM encoding, requester ids.
package mem_bus_arbiter_pkg;

  localparam int XLEN = 32;

  // Instruction refills are always full 32-bit words.
  localparam logic [2:0] IC_F3 = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IC = 2'b01,
    ST_BUSY_DM = 2'b10
  } state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DM = 1'b1
  } req_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IC, DM and memory-side signals around the arbiter.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic            i_IC_req;
  logic [XLEN-1:0] i_IC_addr;
  logic            o_IC_ready;
  logic [XLEN-1:0] o_IC_rdata;

  logic            i_DM_rd;
  logic            i_DM_wr;
  logic [XLEN-1:0] i_DM_addr;
  logic [XLEN-1:0] i_DM_wd;
  logic [2:0]      i_DM_f3;
  logic            i_DM_atomic;
  logic            o_DM_ready;
  logic [XLEN-1:0] o_DM_rdata;

  logic            o_MEM_req;
  logic            o_MEM_wen;
  logic [XLEN-1:0] o_MEM_addr;
  logic [XLEN-1:0] o_MEM_wd;
  logic [2:0]      o_MEM_f3;
  logic            i_MEM_ready;
  logic [XLEN-1:0] i_MEM_rdata;

  // slave: the arbiter itself; master: the requesters and memory around it
  modport slave (
    input  i_IC_req, i_IC_addr,
    output o_IC_ready, o_IC_rdata,
    input  i_DM_rd, i_DM_wr, i_DM_addr, i_DM_wd, i_DM_f3, i_DM_atomic,
    output o_DM_ready, o_DM_rdata,
    output o_MEM_req, o_MEM_wen, o_MEM_addr, o_MEM_wd, o_MEM_f3,
    input  i_MEM_ready, i_MEM_rdata
  );

  modport master (
    output i_IC_req, i_IC_addr,
    input  o_IC_ready, o_IC_rdata,
    output i_DM_rd, i_DM_wr, i_DM_addr, i_DM_wd, i_DM_f3, i_DM_atomic,
    input  o_DM_ready, o_DM_rdata,
    input  o_MEM_req, o_MEM_wen, o_MEM_addr, o_MEM_wd, o_MEM_f3,
    output i_MEM_ready, i_MEM_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker; IC can be masked off while a DM atomic lock is held.
module rr_arb2
  import mem_bus_arbiter_pkg::*;
(
  input  logic req_ic,
  input  logic req_dm,
  input  logic mask_ic,
  input  req_e last,
  output logic gnt_ic,
  output logic gnt_dm
);

  logic p_ic;

  assign p_ic = req_ic & ~mask_ic;

  always_comb begin
    gnt_ic = 1'b0;
    gnt_dm = 1'b0;
    if (p_ic && req_dm) begin
      // Tie goes to whoever was not served last.
      gnt_ic = (last == REQ_DM);
      gnt_dm = (last == REQ_IC);
    end else begin
      gnt_ic = p_ic;
      gnt_dm = req_dm;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between IC refill and DM accesses: round-robin grants,
// DM lock for atomic sequences, released after LOCK_TIMEOUT idle cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input logic              i_clk,
  input logic              i_rst,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state, state_nxt;
  req_e             last, last_nxt;
  logic             lock, lock_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic dm_req;
  logic arb_req_ic, arb_req_dm, arb_mask_ic;
  logic gnt_ic, gnt_dm;
  logic handoff;

  assign dm_req = bus.i_DM_rd | bus.i_DM_wr;

  // In a completion cycle the finishing requester drops out, and a completing
  // DM access masks IC with the lock value it is about to write.
  assign arb_req_ic  = bus.i_IC_req & (state != ST_BUSY_IC);
  assign arb_req_dm  = dm_req & (state != ST_BUSY_DM);
  assign arb_mask_ic = (state == ST_BUSY_DM) ? bus.i_DM_atomic : lock;

  rr_arb2 u_rr_arb2 (
    .req_ic  (arb_req_ic),
    .req_dm  (arb_req_dm),
    .mask_ic (arb_mask_ic),
    .last    (last),
    .gnt_ic  (gnt_ic),
    .gnt_dm  (gnt_dm)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      last  <= REQ_IC;
      lock  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      lock  <= lock_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_nxt       = last;
    lock_nxt       = lock;
    cnt_nxt        = cnt;
    handoff        = 1'b0;
    bus.o_MEM_req  = 1'b0;
    bus.o_MEM_wen  = 1'b0;
    bus.o_MEM_addr = '0;
    bus.o_MEM_wd   = '0;
    bus.o_MEM_f3   = '0;
    bus.o_IC_ready = 1'b0;
    bus.o_IC_rdata = '0;
    bus.o_DM_ready = 1'b0;
    bus.o_DM_rdata = '0;

    case (state)
      ST_IDLE: begin
        handoff = 1'b1;
        if (lock && !dm_req) begin
          if (cnt == CNT_LAST) begin
            lock_nxt = 1'b0;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_BUSY_IC: begin
        if (!i_rst) begin
          bus.o_MEM_req  = 1'b1;
          bus.o_MEM_addr = bus.i_IC_addr;
          bus.o_MEM_f3   = IC_F3;
          bus.o_IC_ready = bus.i_MEM_ready;
          bus.o_IC_rdata = bus.i_MEM_ready ? bus.i_MEM_rdata : '0;
        end
        handoff = bus.i_MEM_ready;
      end
      ST_BUSY_DM: begin
        if (!i_rst) begin
          bus.o_MEM_req  = 1'b1;
          bus.o_MEM_wen  = bus.i_DM_wr;
          bus.o_MEM_addr = bus.i_DM_addr;
          bus.o_MEM_wd   = bus.i_DM_wd;
          bus.o_MEM_f3   = bus.i_DM_f3;
          bus.o_DM_ready = bus.i_MEM_ready;
          bus.o_DM_rdata = bus.i_MEM_ready ? bus.i_MEM_rdata : '0;
        end
        if (bus.i_MEM_ready) begin
          handoff  = 1'b1;
          lock_nxt = bus.i_DM_atomic;
          cnt_nxt  = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Grant straight from IDLE or from a completion cycle, so no bubble when the other side waits.
    if (handoff) begin
      state_nxt = ST_IDLE;
      if (gnt_ic) begin
        state_nxt = ST_BUSY_IC;
        last_nxt  = REQ_IC;
      end else if (gnt_dm) begin
        state_nxt = ST_BUSY_DM;
        last_nxt  = REQ_DM;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus a lock-timeout sequence.
module tb_mem_bus_arbiter;

  localparam int LT = 4;

  logic i_clk = 1'b1;
  logic i_rst;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.LOCK_TIMEOUT(LT), .CNT_W(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dm_rd;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [2:0]  dm_f3;
    logic        dm_atomic;
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic        ic_ready;
    logic [31:0] ic_rdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t vq[$];

  function automatic in_t vin(logic rst, logic icr, logic [31:0] ica, logic rd, logic wr,
                              logic [31:0] da, logic [31:0] wd, logic [2:0] f3, logic at,
                              logic mr, logic [31:0] mrd);
    in_t v;
    v.rst = rst;      v.ic_req = icr;   v.ic_addr = ica;
    v.dm_rd = rd;     v.dm_wr = wr;     v.dm_addr = da;
    v.dm_wd = wd;     v.dm_f3 = f3;     v.dm_atomic = at;
    v.mem_ready = mr; v.mem_rdata = mrd;
    return v;
  endfunction

  function automatic out_t vo_ic(logic [31:0] a, logic rdy, logic [31:0] rd);
    out_t o = '0;
    o.req = 1'b1; o.addr = a; o.f3 = 3'b010;
    o.ic_ready = rdy; o.ic_rdata = rd;
    return o;
  endfunction

  function automatic out_t vo_dm(logic wen, logic [31:0] a, logic [31:0] wd, logic [2:0] f3,
                                 logic rdy, logic [31:0] rd);
    out_t o = '0;
    o.req = 1'b1; o.wen = wen; o.addr = a; o.wd = wd; o.f3 = f3;
    o.dm_ready = rdy; o.dm_rdata = rd;
    return o;
  endfunction

  function automatic void add(string n, in_t i, out_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    vq.push_back(v);
  endfunction

  task automatic apply(input in_t v);
    i_rst           = v.rst;
    bus.i_IC_req    = v.ic_req;
    bus.i_IC_addr   = v.ic_addr;
    bus.i_DM_rd     = v.dm_rd;
    bus.i_DM_wr     = v.dm_wr;
    bus.i_DM_addr   = v.dm_addr;
    bus.i_DM_wd     = v.dm_wd;
    bus.i_DM_f3     = v.dm_f3;
    bus.i_DM_atomic = v.dm_atomic;
    bus.i_MEM_ready = v.mem_ready;
    bus.i_MEM_rdata = v.mem_rdata;
  endtask

  function automatic out_t sample();
    out_t o;
    o.req = bus.o_MEM_req;       o.wen = bus.o_MEM_wen;
    o.addr = bus.o_MEM_addr;     o.wd = bus.o_MEM_wd;     o.f3 = bus.o_MEM_f3;
    o.ic_ready = bus.o_IC_ready; o.ic_rdata = bus.o_IC_rdata;
    o.dm_ready = bus.o_DM_ready; o.dm_rdata = bus.o_DM_rdata;
    return o;
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  initial begin
    int idle;
    bit found;

    // Reset with both requesting, then first grant goes to DM
    add("rst_hold0",     vin(1,1,32'h100,1,0,32'h2000,0,3'b100,0,0,0), '0);
    add("rst_hold1",     vin(1,1,32'h100,1,0,32'h2000,0,3'b100,0,0,0), '0);
    add("post_rst_idle", vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,0,0), '0);
    add("first_grant_dm",vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,0,0), vo_dm(0,32'h2000,0,3'b100,0,0));
    add("dm_done",       vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,1,32'h11112222),
                         vo_dm(0,32'h2000,0,3'b100,1,32'h11112222));
    add("ic_after_dm",   vin(0,1,32'h100,0,0,0,0,0,0,1,32'hA5A5A5A5), vo_ic(32'h100,1,32'hA5A5A5A5));
    add("idle0",         vin(0,0,0,0,0,0,0,0,0,0,0), '0);
    // Lone IC refill, memory ready on the third busy cycle
    add("lone_ic_idle",  vin(0,1,32'h100,0,0,0,0,0,0,0,0), '0);
    add("lone_ic_wait1", vin(0,1,32'h100,0,0,0,0,0,0,0,0), vo_ic(32'h100,0,0));
    add("lone_ic_wait2", vin(0,1,32'h100,0,0,0,0,0,0,0,0), vo_ic(32'h100,0,0));
    add("lone_ic_done",  vin(0,1,32'h100,0,0,0,0,0,0,1,32'hDEADBEEF), vo_ic(32'h100,1,32'hDEADBEEF));
    add("lone_ic_after", vin(0,0,0,0,0,0,0,0,0,0,0), '0);
    // Contention, memory ready every cycle: DM, IC, DM, IC back to back
    add("cont_idle",     vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,1,0), '0);
    add("cont_dm1",      vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,1,1), vo_dm(0,32'h2000,0,3'b100,1,1));
    add("cont_ic1",      vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,1,2), vo_ic(32'h100,1,2));
    add("cont_dm2",      vin(0,1,32'h100,1,0,32'h2000,0,3'b100,0,1,3), vo_dm(0,32'h2000,0,3'b100,1,3));
    add("cont_ic2",      vin(0,1,32'h100,0,0,0,0,0,0,1,4), vo_ic(32'h100,1,4));
    add("cont_end",      vin(0,0,0,0,0,0,0,0,0,0,0), '0);
    // DM writes, including rd and wr both high
    add("wr_idle",       vin(0,0,0,0,1,32'h2004,32'h55,3'b000,0,0,0), '0);
    add("wr_wait",       vin(0,0,0,0,1,32'h2004,32'h55,3'b000,0,0,0), vo_dm(1,32'h2004,32'h55,3'b000,0,0));
    add("wr_done",       vin(0,0,0,0,1,32'h2004,32'h55,3'b000,0,1,32'hCAFE),
                         vo_dm(1,32'h2004,32'h55,3'b000,1,32'hCAFE));
    add("rdwr_idle",     vin(0,0,0,1,1,32'h2008,32'h66,3'b001,0,0,0), '0);
    add("rdwr_is_write", vin(0,0,0,1,1,32'h2008,32'h66,3'b001,0,1,0), vo_dm(1,32'h2008,32'h66,3'b001,1,0));
    add("idle1",         vin(0,0,0,0,0,0,0,0,0,0,0), '0);
    // Atomic lock masks IC until a non-atomic DM access completes
    add("amo_idle",      vin(0,0,0,1,0,32'h3000,0,3'b010,1,0,0), '0);
    add("amo_wait",      vin(0,1,32'h140,1,0,32'h3000,0,3'b010,1,0,0), vo_dm(0,32'h3000,0,3'b010,0,0));
    add("amo_done",      vin(0,1,32'h140,1,0,32'h3000,0,3'b010,1,1,32'h77), vo_dm(0,32'h3000,0,3'b010,1,32'h77));
    add("lock_mask1",    vin(0,1,32'h140,0,0,0,0,0,0,0,0), '0);
    add("lock_mask2",    vin(0,1,32'h140,0,0,0,0,0,0,0,0), '0);
    add("lock_wr_idle",  vin(0,1,32'h140,0,1,32'h3000,32'h99,3'b010,0,0,0), '0);
    add("lock_wr_done",  vin(0,1,32'h140,0,1,32'h3000,32'h99,3'b010,0,1,0), vo_dm(1,32'h3000,32'h99,3'b010,1,0));
    add("unlock_ic",     vin(0,1,32'h140,0,0,0,0,0,0,0,0), vo_ic(32'h140,0,0));
    add("unlock_ic_done",vin(0,1,32'h140,0,0,0,0,0,0,1,32'hBEEF0001), vo_ic(32'h140,1,32'hBEEF0001));
    add("idle2",         vin(0,0,0,0,0,0,0,0,0,0,0), '0);
    // Reset in the middle of an IC transaction
    add("rst_mid_idle",  vin(0,1,32'h180,0,0,0,0,0,0,0,0), '0);
    add("rst_mid_busy",  vin(0,1,32'h180,0,0,0,0,0,0,0,0), vo_ic(32'h180,0,0));
    add("rst_mid_assert",vin(1,1,32'h180,0,0,0,0,0,0,0,0), '0);
    add("rst_mid_release",vin(0,1,32'h180,0,0,0,0,0,0,0,0), '0);
    add("rst_mid_regrant",vin(0,1,32'h180,0,0,0,0,0,0,1,32'h5), vo_ic(32'h180,1,32'h5));
    add("idle3",         vin(0,0,0,0,0,0,0,0,0,0,0), '0);

    #1;
    foreach (vq[i]) begin
      apply(vq[i].i);
      @(negedge i_clk);
      check_out(vq[i].name, vq[i].o);
      @(posedge i_clk);
      #1;
    end

    // Lock timeout: atomic DM read completes, then only IC requests
    apply(vin(0,0,0,1,0,32'h4000,0,3'b010,1,0,0));
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (bus.o_MEM_req) begin
        found = 1'b1;
        break;
      end
      @(posedge i_clk);
      #1;
    end
    check_int("to_amo_granted", int'(found), 1);
    @(posedge i_clk);
    #1;
    bus.i_MEM_ready = 1'b1;
    bus.i_MEM_rdata = 32'h1234;
    @(negedge i_clk);
    check_out("to_amo_done", vo_dm(0,32'h4000,0,3'b010,1,32'h1234));
    @(posedge i_clk);
    #1;
    apply(vin(0,1,32'h1C0,0,0,0,0,0,0,0,0));
    idle  = 0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (bus.o_MEM_req) begin
        found = 1'b1;
        break;
      end
      idle++;
      @(posedge i_clk);
      #1;
    end
    // Lock held for LT idle cycles, then one IDLE cycle to make the grant.
    check_int("to_idle_cycles", found ? idle : -1, LT + 1);
    check_out("to_ic_granted", vo_ic(32'h1C0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
